// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry in-order store buffer between the memory stage
// and the data cache. Stores drain one at a time under the dhit handshake.
// Loads are checked against pending entries and are either forwarded or
// stalled.
// Build option: define SB_FWD_EN to enable load forwarding. Without it,
// any word-address match stalls the load, and ld_fwd/ld_data are tied low.
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_valid,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  input  logic                      st_byte,
  output logic                      st_ready,
  input  logic                      ld_valid,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic                      ld_byte,
  output logic                      ld_fwd,
  output logic [DATA_W-1:0]         ld_data,
  output logic                      ld_stall,
  output logic                      cache_wr,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic [DATA_W-1:0]         cache_wdata,
  output logic                      cache_byte,
  input  logic                      dhit,
  output logic                      sb_empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_byte [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_hit;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_hit_idx;

  // st_ready looks only at the registered count, so a full buffer refuses
  // a push even when a pop happens at the same edge.
  assign st_ready    = (r_count != CNT_W'(DEPTH));
  assign sb_empty    = (r_count == '0);
  assign count       = r_count;
  assign cache_wr    = !sb_empty;
  assign cache_addr  = r_addr[r_rp];
  assign cache_wdata = r_data[r_rp];
  assign cache_byte  = r_byte[r_rp];
  assign w_push      = st_valid && st_ready;
  assign w_pop       = cache_wr && dhit;

`ifdef SB_FWD_EN
  // Extract byte lane sel from a word, zero-extended to the data width.
  function automatic logic [DATA_W-1:0] f_lane(input logic [DATA_W-1:0] d,
                                               input logic [1:0] sel);
    f_lane = DATA_W'(d[{sel, 3'b000} +: 8]);
  endfunction
`endif

  // Pointer and occupancy control; the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_addr[r_wp] <= st_addr;
      r_data[r_wp] <= st_data;
      r_byte[r_wp] <= st_byte;
    end
  end

  // Find the youngest occupied entry whose word address matches the load.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rp + PTR_W'(k);
      if ((CNT_W'(k) < r_count) &&
          (r_addr[w_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        w_hit     = 1'b1;
        w_hit_idx = w_idx;
      end
    end
  end

`ifdef SB_FWD_EN
  // Forward or stall based on the kind of the youngest matching entry.
  always_comb begin
    ld_fwd   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (ld_valid && w_hit) begin
      if (!r_byte[w_hit_idx]) begin
        ld_fwd  = 1'b1;
        ld_data = ld_byte ? f_lane(r_data[w_hit_idx], ld_addr[1:0])
                          : r_data[w_hit_idx];
      end else if (ld_byte && (r_addr[w_hit_idx] == ld_addr)) begin
        ld_fwd  = 1'b1;
        ld_data = DATA_W'(r_data[w_hit_idx][7:0]);
      end else begin
        ld_stall = 1'b1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{ld_byte, ld_addr[1:0], w_hit_idx};

  // Without forwarding every word-address conflict holds the load.
  always_comb begin
    ld_fwd   = 1'b0;
    ld_data  = '0;
    ld_stall = ld_valid && w_hit;
  end
`endif

endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised, DEPTH-entry FIFO store buffer between the pipelined core's memory stage and the data cache.
- Accepts word and byte stores from the core without stalling on a cache miss.
- Drains stores to the cache in program order, one at a time, under the cache's `dhit` handshake.
- Checks every load against the pending entries: forwards matching data, or stalls the load.
- Successor to the core's direct MemWrite/ALUOut/WriteData path: same signal set, generalised in width and depth.

## Interface
Parameters
- `DATA_W`, 32: store and load data width, bytes addressed little-endian.
- `ADDR_W`, 32: byte address width.
- `DEPTH`, 4: number of entries; power of two, ≥ 2.

Ports
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `st_valid` input 1: core presents a store this cycle.
- `st_addr` input ADDR_W: store byte address.
- `st_data` input DATA_W: store data; a byte store uses bits [7:0].
- `st_byte` input 1: 1 = byte store, 0 = word store.
- `st_ready` output 1: buffer can accept a store (`count < DEPTH`).
- `ld_valid` input 1: core presents a load this cycle.
- `ld_addr` input ADDR_W: load byte address.
- `ld_byte` input 1: 1 = byte load.
- `ld_fwd` output 1: load data is supplied by the buffer on `ld_data`.
- `ld_data` output DATA_W: forwarded data; a byte result is zero-extended in [7:0].
- `ld_stall` output 1: load must hold; it conflicts with a pending entry that cannot be forwarded.
- `cache_wr` output 1: head entry is presented to the cache.
- `cache_addr` output ADDR_W: head entry address.
- `cache_wdata` output DATA_W: head entry data.
- `cache_byte` output 1: head entry is a byte store.
- `dhit` input 1: cache completes the presented write at this edge.
- `sb_empty` output 1: no pending entries; the core uses it for fence/drain.
- `count` output $clog2(DEPTH)+1: number of occupied entries.

## Operation
Storage
- Circular array of {addr, data, byte} entries.
- Write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy `count`, range 0..DEPTH.

Push
- Occurs at an edge where `st_valid && st_ready`; writes the entry at `wp`, then `wp++`.
- A store offered while full (`st_ready = 0`) is not captured; the core must hold it.

Pop
- Occurs at an edge where `cache_wr && dhit`; `rp++`.
- `cache_wr = !sb_empty`; the `cache_*` outputs always reflect entry[rp].
- `dhit` sampled while empty has no effect.

Push and pop at the same edge
- Both take effect; `count` is unchanged.
- When full, push is refused even if a pop occurs at the same edge; `st_ready` depends only on registered `count`.

Load check (combinational, only when `ld_valid`)
- A load matches an entry when their word addresses (`addr[ADDR_W-1:2]`) are equal.
- Only the youngest matching entry is considered.
- Action by youngest match:
  - no match → `ld_fwd = 0`, `ld_stall = 0`; the core reads the cache.
  - word entry, word load → forward the entry data.
  - word entry, byte load → forward byte lane `ld_addr[1:0]`, zero-extended.
  - byte entry, byte load at the same full address → forward the byte, zero-extended.
  - byte entry, any other load → `ld_stall = 1`.
- `ld_stall` deasserts once the conflicting entry has popped.
- The check sees only entries registered before the current edge.

Simultaneous `st_valid` and `ld_valid`
- Not allowed: the core issues one memory operation per cycle.
- Behaviour in that case is undefined; the bench asserts against it.

## Timing
- Reset values: `count = 0`, `wp = rp = 0`, `sb_empty = 1`, `st_ready = 1`, `cache_wr = 0`, `ld_fwd = 0`, `ld_stall = 0`, `ld_data = 0`.
- Reset asserted mid-drain: every entry is discarded at that edge, and `cache_wr` is 0 the following cycle.
- Push into an empty buffer at edge N → `cache_wr = 1` from cycle N+1.
- `cache_addr`, `cache_wdata` and `cache_byte` stay stable while `cache_wr` is high until the `dhit` edge.
- After a pop at edge M, the next entry is presented in cycle M+1; back-to-back drain is one entry per cycle while `dhit` stays high.
- Load forwarding and stall decisions are combinational, with zero-cycle latency.
- `count`, `sb_empty` and `st_ready` are registered and change only on edges.

## Configuration
- `SB_FWD_EN` defined: load forwarding as described above.
- `SB_FWD_EN` undefined:
  - forwarding logic is removed and `ld_fwd` and `ld_data` are tied to 0;
  - any load that matches any pending entry on word address asserts `ld_stall` until all matching entries have popped.

## Test plan
- Reset, then push word 0xDEADBEEF @0x100 with `dhit` held low → `cache_wr = 1`, `cache_addr = 0x100`, `count = 1`. Raise `dhit` for one cycle → `sb_empty = 1` next cycle.
- Fill DEPTH = 4 with `dhit = 0` → `st_ready = 0`. Offer a fifth store → not captured. Pop with `dhit` pulses → entries drain in order @0x0, 0x4, 0x8, 0xC, and `wp`/`rp` wrap back to 0.
- With `SB_FWD_EN`: push word 0x11223344 @0x200, then byte load @0x202 → `ld_fwd = 1`, `ld_data = 0x22`.
- Push word 0xAAAAAAAA @0x300, then word 0xBBBBBBBB @0x300; word load @0x300 → `ld_data = 0xBBBBBBBB`, the youngest entry.
- Push byte 0x5A @0x401, then word load @0x400 → `ld_stall = 1`. After the entry pops → `ld_stall = 0` and `ld_fwd = 0`. Without `SB_FWD_EN`, the word load of the previous scenario stalls instead of forwarding.
- Full buffer, pop and offered push at the same edge → push refused and `count` = 3. Assert `reset` with 3 entries pending → `count = 0` and `cache_wr = 0` next cycle.
